// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, word width and
// the request address legality check.
package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A request errors when it is not word aligned or points past the array;
    // out-of-range addresses never alias onto low words.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_width);
        logic high_bits;
        high_bits = (addr >> (addr_width + 2)) != 32'd0;
        return (addr[1:0] != 2'b00) || high_bits;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM; one read or write per enabled edge.
// Contents are intentionally not reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side end of the CPU fetch/MEM interface: one request at a time,
// fixed access latency, held response until the requester accepts it.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    // Handshakes: a request transfers on an edge where req_valid && req_ready;
    // a response transfers on an edge where resp_valid && resp_ready, and
    // resp_valid/resp_rdata/resp_err hold steady until that edge.

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t            state, state_next;
    logic [3:0]        count, count_next;
    logic              lat_write;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic              resp_err_q;
    logic              resp_is_load;

    logic              access;
    logic              acc_write;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_err;
    logic              ram_en;
    logic [WORD_W-1:0] ram_rdata;

    always_comb begin
        state_next = state;
        count_next = count;
        req_ready  = 1'b0;
        access     = 1'b0;
        acc_write  = lat_write;
        acc_addr   = lat_addr;
        acc_wdata  = lat_wdata;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                // With LATENCY=1 the array is accessed straight from the request bus.
                acc_write = req_write;
                acc_addr  = req_addr;
                acc_wdata = req_wdata;
                if (req_valid) begin
                    count_next = LAT_M1;
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        access     = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                count_next = count - 4'd1;
                if (count == 4'd1) begin
                    state_next = RESP;
                    access     = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign acc_err = addr_err(acc_addr, ADDR_WIDTH);
    assign ram_en  = access && !acc_err && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= 4'd0;
            lat_write    <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            resp_err_q   <= 1'b0;
            resp_is_load <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (state == IDLE && req_valid) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (access) begin
                resp_err_q   <= acc_err;
                resp_is_load <= !acc_write && !acc_err;
            end
        end
    end

    mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .en   (ram_en),
        .we   (acc_write),
        .addr (acc_addr[ADDR_WIDTH+1:2]),
        .wdata(acc_wdata),
        .rdata(ram_rdata)
    );

    // The RAM output register only changes on RESP entry, so it is stable in RESP.
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && resp_err_q;
    assign resp_rdata = (resp_valid && resp_is_load) ? ram_rdata : 32'd0;

endmodule
